// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and checks them.
// Define SYSID_CHECK_AUTOSTART_EN to launch one check automatically after each reset release.
module sysid_checker #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [31:0]       EXPECTED_ID = 32'd305419896,
  parameter logic [31:0]       EXPECTED_TS = 32'd1478288201,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       TIMEOUT     = 1023
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              id_ok,
  output logic              ts_ok,
  output logic              timeout,
  output logic [31:0]       id_value,
  output logic [31:0]       ts_value
);

  localparam logic [15:0]       TO_LIMIT = 16'(TIMEOUT);
  localparam logic [ADDR_W-1:0] TS_ADDR  = BASE_ADDR + ADDR_W'(4);

  typedef enum logic [2:0] {IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, DONE} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic        start_req;

`ifdef SYSID_CHECK_AUTOSTART_EN
  logic auto_start;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) auto_start <= 1'b1;
    else          auto_start <= 1'b0;
  end

  assign start_req = start | auto_start;
`else
  assign start_req = start;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      avm_address <= '0;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_req) begin
            state       <= RD_ID;
            cnt         <= '0;
            avm_address <= BASE_ADDR;
            avm_read    <= 1'b1;
            busy        <= 1'b1;
            pass        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
          end
        end
        // The limit check wins over a same-cycle handshake or data beat.
        RD_ID, RD_TS, WAIT_ID, WAIT_TS: begin
          if (cnt == TO_LIMIT) begin
            state    <= DONE;
            done     <= 1'b1;
            timeout  <= 1'b1;
            avm_read <= 1'b0;
            pass     <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
            if (state == RD_ID || state == RD_TS) begin
              if (!avm_waitrequest) begin
                avm_read <= 1'b0;
                state    <= (state == RD_ID) ? WAIT_ID : WAIT_TS;
              end
            end else if (avm_readdatavalid) begin
              if (state == WAIT_ID) begin
                id_value    <= avm_readdata;
                id_ok       <= (avm_readdata == EXPECTED_ID);
                state       <= RD_TS;
                cnt         <= '0;
                avm_address <= TS_ADDR;
                avm_read    <= 1'b1;
              end else begin
                ts_value <= avm_readdata;
                ts_ok    <= (avm_readdata == EXPECTED_TS);
                pass     <= id_ok & (avm_readdata == EXPECTED_TS);
                state    <= DONE;
                done     <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Randomised scoreboard bench for sysid_checker with a behavioural Avalon slave.
module tb_sysid_checker;
  localparam logic [31:0] EXP_ID = 32'd305419896;
  localparam logic [31:0] EXP_TS = 32'd1478288201;
  localparam logic [31:0] BASE   = 32'h0;
  localparam int          TMO    = 15;

  logic        clock = 1'b0;
  logic        reset_n, start;
  logic [31:0] avm_address;
  logic        avm_read, avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata;
  logic        busy, done, pass, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          cfg_w, cfg_l;
  logic [31:0] cfg_id, cfg_ts;
  bit          spur_en;

  typedef struct {
    bit          pass, id_ok, ts_ok, to;
    logic [31:0] idv, tsv;
    int          start_cyc, lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] addr_q[$];

  sysid_checker #(
    .ADDR_W(32), .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
    .BASE_ADDR(BASE), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .done(done), .pass(pass), .id_ok(id_ok), .ts_ok(ts_ok),
    .timeout(timeout), .id_value(id_value), .ts_value(ts_value)
  );

  initial forever #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: each read costs w+1+l cycles; over-limit when w+l reaches TMO.
  function automatic void expect_check(input int w, input int l, input logic [31:0] id,
                                       input logic [31:0] ts, input int s);
    exp_t e;
    e.start_cyc = s;
    if (w < TMO) addr_q.push_back(BASE);
    if (w + l >= TMO) begin
      e.to = 1; e.pass = 0; e.id_ok = 0; e.ts_ok = 0; e.idv = '0; e.tsv = '0;
      e.lat = TMO + 2;
    end else begin
      addr_q.push_back(BASE + 32'd4);
      e.to = 0; e.idv = id; e.tsv = ts;
      e.id_ok = (id == EXP_ID); e.ts_ok = (ts == EXP_TS);
      e.pass = e.id_ok && e.ts_ok;
      e.lat = 1 + 2 * (w + 1 + l);
    end
    sb.push_back(e);
  endfunction

  // Slave: waitrequest for cfg_w cycles per read, data cfg_l cycles after acceptance.
  initial begin
    int          wr_left, resp_cnt;
    bit          resp_pend, prev_read;
    logic [31:0] resp_data, prev_addr;
    wr_left = 0; resp_cnt = 0; resp_pend = 0; prev_read = 0;
    resp_data = '0; prev_addr = '0;
    avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = '0;
    forever begin
      @(negedge clock);
      avm_readdatavalid = 0;
      avm_readdata      = $urandom;
      avm_waitrequest   = 0;
      if (resp_pend) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          avm_readdatavalid = 1;
          avm_readdata      = resp_data;
          resp_pend         = 0;
        end
      end
      if (reset_n && avm_read) begin
        if (!prev_read) wr_left = cfg_w;
        else chk("addr_stable", avm_address, prev_addr);
        if (wr_left > 0) begin
          avm_waitrequest = 1;
          wr_left--;
        end else begin
          if (addr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_addr actual=%0h expected=no_read", avm_address);
          end else begin
            chk("rd_addr", avm_address, addr_q.pop_front());
          end
          resp_pend = 1;
          resp_cnt  = cfg_l;
          resp_data = (avm_address == BASE + 32'd4) ? cfg_ts : cfg_id;
        end
        if (spur_en && !avm_readdatavalid && $urandom_range(0, 2) == 0)
          avm_readdatavalid = 1;
      end
      prev_read = avm_read;
      prev_addr = avm_address;
    end
  end

  // Monitor: pops one expectation per done pulse.
  initial begin
    bit   prev_done, last_pass;
    exp_t e;
    prev_done = 0; last_pass = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_done = 0;
        continue;
      end
      if (prev_done) begin
        chk("done_pulse", done, 0);
        chk("busy_clear", busy, 0);
        chk("pass_held", pass, last_pass);
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("latency", cyc - e.start_cyc, e.lat);
          chk("pass", pass, e.pass);
          chk("id_ok", id_ok, e.id_ok);
          chk("ts_ok", ts_ok, e.ts_ok);
          chk("timeout", timeout, e.to);
          chk("id_value", id_value, e.idv);
          chk("ts_value", ts_value, e.tsv);
          chk("busy_at_done", busy, 1);
          last_pass = e.pass;
        end
      end
      prev_done = done;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read"}, avm_read, 0);
    chk({tag, "_addr"}, avm_address, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_id_ok"}, id_ok, 0);
    chk({tag, "_ts_ok"}, ts_ok, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_id_value"}, id_value, 0);
    chk({tag, "_ts_value"}, ts_value, 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (sb.size() == 0 && !busy) break;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic post_reset();
`ifdef SYSID_CHECK_AUTOSTART_EN
    expect_check(cfg_w, cfg_l, cfg_id, cfg_ts, cyc);
    wait_idle();
`else
    repeat (10) @(negedge clock);
    chk("no_autostart_busy", busy, 0);
    chk("no_autostart_read", avm_read, 0);
    chk("no_autostart_id", id_value, 0);
`endif
  endtask

  task automatic set_cfg(input int w, input int l, input logic [31:0] id,
                         input logic [31:0] ts, input bit spur);
    cfg_w = w; cfg_l = l; cfg_id = id; cfg_ts = ts; spur_en = spur;
  endtask

  task automatic run_check(input int w, input int l, input logic [31:0] id,
                           input logic [31:0] ts, input bit spur, input int gap);
    bit seen;
    seen = 0;
    set_cfg(w, l, id, ts, spur);
    @(negedge clock);
    start = 1;
    expect_check(w, l, id, ts, cyc);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (done) begin
        seen = 1;
        break;
      end
      start = (spur && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 0;
    chk("done_seen", seen, 1);
    repeat (gap) @(negedge clock);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    reset_n = 0;
    start   = 0;
    set_cfg(0, 1, EXP_ID, EXP_TS, 0);
    repeat (3) @(negedge clock);
    chk_all_zero("rst");
    reset_n = 1;
    post_reset();

    run_check(0, 1, EXP_ID, EXP_TS, 0, 3);
    run_check(0, 1, 32'hDEADBEEF, EXP_TS, 0, 3);
    run_check(3, 1, EXP_ID, EXP_TS, 0, 3);
    run_check(0, 1, EXP_ID, 32'h0, 1, 3);
    run_check(8, 6, EXP_ID, EXP_TS, 0, 3);
    run_check(9, 6, EXP_ID, EXP_TS, 0, 5);
    run_check(0, 40, EXP_ID, EXP_TS, 0, 45);
    run_check(30, 1, EXP_ID, EXP_TS, 0, 5);

    // Start held high across done relaunches immediately.
    set_cfg(0, 1, EXP_ID, EXP_TS, 0);
    @(negedge clock);
    start = 1;
    expect_check(0, 1, EXP_ID, EXP_TS, cyc);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk("held_first_done", seen, 1);
    expect_check(0, 1, EXP_ID, EXP_TS, cyc + 1);
    @(negedge clock);
    @(negedge clock);
    start = 0;
    wait_idle();

    // Reset in the middle of the timestamp read.
    set_cfg(0, 6, EXP_ID, EXP_TS, 0);
    @(negedge clock);
    start = 1;
    expect_check(0, 6, EXP_ID, EXP_TS, cyc);
    @(negedge clock);
    start = 0;
    repeat (9) @(negedge clock);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_id", id_value, EXP_ID);
    #2 reset_n = 0;
    #1 chk_all_zero("midrst");
    sb.delete();
    addr_q.delete();
    @(negedge clock);
    reset_n = 1;
    post_reset();

    for (int n = 0; n < 20; n++) begin
      logic [31:0] id, ts;
      id = $urandom_range(0, 1) ? EXP_ID : $urandom;
      ts = $urandom_range(0, 1) ? EXP_TS : $urandom;
      run_check($urandom_range(0, 5), $urandom_range(1, 6), id, ts,
                1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    wait_idle();
    chk("addr_q_empty", addr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
